// File: rtl/ccff_pkg.sv
// ccff_pkg: loader state encoding, default chain/word geometry and a width helper.
package ccff_pkg;
  localparam int DEF_CHAIN_LEN = 1024;
  localparam int DEF_DATA_W = 8;
  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_e;
  function automatic int idx_w(int w);
    return w > 1 ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/ccff_loader_if.sv
// ccff_loader_if: valid/ready word stream from a bitstream source into the loader.
interface ccff_loader_if #(parameter int DATA_W = ccff_pkg::DEF_DATA_W);
  logic [DATA_W-1:0] s_data;
  logic s_valid;
  logic s_ready;
  modport master (output s_data, s_valid, input s_ready);
  modport slave (input s_data, s_valid, output s_ready);
endinterface

// File: rtl/ccff_piso.sv
// ccff_piso: parallel-in/serial-out word register, MSB first, flags the word's last bit.
module ccff_piso import ccff_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              msb_o,
  output logic              last_o
);
  localparam int IW = idx_w(DATA_W);
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [IW-1:0] idx_q, idx_d;
  // a load wins over a shift so a back-to-back word replaces the one just finished
  always_comb begin
    sr_d = load_i ? data_i : shift_i ? sr_q << 1 : sr_q;
    idx_d = load_i ? '0 : shift_i ? idx_q + IW'(1) : idx_q;
  end
  always_ff @(posedge prog_clk or negedge pReset)
    if (!pReset) begin
      sr_q <= '0;
      idx_q <= '0;
    end else begin
      sr_q <= sr_d;
      idx_q <= idx_d;
    end
  assign msb_o = sr_q[DATA_W-1];
  assign last_o = idx_q == IW'(DATA_W - 1);
endmodule

// File: rtl/ccff_loader.sv
// ccff_loader: streams a bitstream MSB first into a CCFF chain, exactly CHAIN_LEN bits,
// with config_enable qualifying only valid bits on ccff_head.
module ccff_loader import ccff_pkg::*; #(
  parameter int CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic prog_clk,
  input  logic pReset,
  input  logic start,
  input  logic abort,
  ccff_loader_if.slave s,
  output logic ccff_head,
  output logic config_enable,
  output logic busy,
  output logic done,
  output logic aborted
);
  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);
  state_e state_q;
  logic [CW-1:0] cnt_q;
  logic head_q, cen_q, done_q, aborted_q;
  logic msb, last, ready, xfer;
  // a refill is offered only on a word's last bit and only if more chain bits remain
  assign ready = state_q == FETCH || (state_q == SHIFT && last && cnt_q != LAST);
  assign xfer = s.s_valid && ready;
  assign s.s_ready = ready;
  ccff_piso #(.DATA_W(DATA_W)) u_piso (
    .prog_clk(prog_clk),
    .pReset(pReset),
    .load_i(xfer),
    .shift_i(state_q == SHIFT),
    .data_i(s.s_data),
    .msb_o(msb),
    .last_o(last)
  );
  always_ff @(posedge prog_clk or negedge pReset)
    if (!pReset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      head_q <= 1'b0;
      cen_q <= 1'b0;
      done_q <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      cen_q <= 1'b0;
      case (state_q)
        IDLE:
          if (start) begin
            state_q <= FETCH;
            cnt_q <= '0;
            done_q <= 1'b0;
            aborted_q <= 1'b0;
          end
        FETCH:
          if (abort) begin
            state_q <= IDLE;
            aborted_q <= 1'b1;
            done_q <= 1'b0;
          end else if (xfer) state_q <= SHIFT;
        SHIFT:
          if (abort) begin
            state_q <= IDLE;
            aborted_q <= 1'b1;
            done_q <= 1'b0;
          end else begin
            head_q <= msb;
            cen_q <= 1'b1;
            cnt_q <= cnt_q + CW'(1);
            state_q <= cnt_q == LAST ? DONE : (last && !xfer) ? FETCH : SHIFT;
          end
        DONE: begin
          state_q <= IDLE;
          done_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign ccff_head = head_q;
  assign config_enable = cen_q;
  assign busy = state_q == FETCH || state_q == SHIFT;
  assign done = done_q;
  assign aborted = aborted_q;
endmodule

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 1024: total configuration-chain bits to shift; legal range 1..65535.
REQ-002 Parameter DATA_W, default 8: bitstream word width; legal range 1..32.
REQ-003 prog_clk  input  1  sole clock; all state on its rising edge.
REQ-004 pReset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse; begins a load, honoured only in IDLE.
REQ-006 abort  input  1  level; terminates an active load.
REQ-007 s_data  input  DATA_W  bitstream word; MSB is shifted first.
REQ-008 s_valid  input  1  s_data valid.
REQ-009 s_ready  output  1  loader accepts s_data this cycle.
REQ-010 ccff_head  output  1  serial bit to the first chain element.
REQ-011 config_enable  output  1  chain shift qualifier; high only on cycles where ccff_head holds a valid bit.
REQ-012 busy  output  1  high in FETCH or SHIFT.
REQ-013 done  output  1  sticky; high after exactly CHAIN_LEN bits shifted; cleared by next start.
REQ-014 aborted  output  1  sticky; high after abort; cleared by next start.

Function
REQ-015 States: IDLE, FETCH, SHIFT, DONE.
REQ-016 IDLE: start=1 -> FETCH; clears done, aborted and bit counter.
REQ-017 FETCH: s_ready=1; on s_valid&s_ready, load word into shift register and go to SHIFT; no valid word -> stay, config_enable=0.
REQ-018 SHIFT: each cycle, drive the shift-register MSB on ccff_head with config_enable=1 (both registered, same edge); shift left; increment bit counter.
REQ-019 s_ready is also high in SHIFT during the cycle the word's last bit is presented; a transfer then reloads the shift register so the next word's MSB follows with no bubble.
REQ-020 Last bit of a word with no transfer -> FETCH; config_enable is 0 in every bubble cycle, so the chain never shifts garbage.
REQ-021 Bit counter reaches CHAIN_LEN -> DONE the next cycle; done=1, config_enable=0, s_ready=0; remaining bits of a partially consumed final word are discarded.
REQ-022 s_ready stays 0 once CHAIN_LEN bits are committed, so no word beyond those needed is accepted.
REQ-023 DONE -> IDLE the following cycle; done stays high.
REQ-024 abort in FETCH or SHIFT -> IDLE the next cycle; config_enable=0 from that edge; aborted=1; done=0; abort has priority over a simultaneous last bit.
REQ-025 start outside IDLE is ignored; abort in IDLE/DONE is ignored.
REQ-026 Bit counter width is clog2(CHAIN_LEN+1); no wrap-around is permitted.
REQ-027 Total config_enable=1 cycles per completed load equals CHAIN_LEN exactly.

Reset
REQ-028 pReset low forces, asynchronously: state=IDLE, ccff_head=0, config_enable=0, s_ready=0, busy=0, done=0, aborted=0, counter=0, shift register=0.
REQ-029 Reset mid-load abandons the load; aborted is not set; chain content is undefined and the load must be restarted.
REQ-030 Deassertion is synchronised externally; the block needs only an asynchronous clear.

Structure
REQ-031 The state encoding enum and the default CHAIN_LEN/DATA_W constants belong in a shared package (ccff_pkg).
REQ-032 One sub-module is natural: ccff_piso (DATA_W parallel-in/serial-out register with load, shift and last-bit flag).
REQ-033 ccff_head and config_enable are driven directly from flops, with no combinational path from s_valid or abort.

Verification
REQ-034 CHAIN_LEN=12, DATA_W=8, words 0xA5, 0x3C held valid -> ccff_head sequence 1,0,1,0,0,1,0,1,0,0,1,1 on 12 consecutive config_enable cycles; done=1; low nibble of 0x3C discarded.
REQ-035 CHAIN_LEN=16, s_valid dropped for 3 cycles after the first word -> exactly 3 config_enable=0 bubble cycles; 16 enable cycles in total; done=1.
REQ-036 CHAIN_LEN=16, abort asserted after 5 bits -> config_enable=0 from the next edge; aborted=1; done=0; IDLE; new start clears aborted.
REQ-037 pReset asserted mid-SHIFT without a clock edge -> all outputs 0 immediately; after release, start plus 12 bits loads normally.
REQ-038 start while busy and abort while IDLE -> no state change; bit count unaffected.
REQ-039 CHAIN_LEN=1, word 0x80 -> one enable cycle with ccff_head=1; done=1; s_ready never re-asserts during the load.
